aes_decrypt_iter: RTL and testbench
===================================

Name: aes_decrypt_iter

Overview:
Iterative, parametrised AES inverse cipher (FIPS-197). Key length is selectable: 128, 192 or 256 bits. It is the sequential successor to the fully combinational aes_decrypt_256 core. Expands a loaded key once into an internal round-key store. It then decrypts one 128-bit block per Nr+1 cycles, executing one inverse round per clock. Sits behind valid/ready streams so it can be dropped between a host FIFO and a plaintext sink. Reuses the codebase's existing S-box, inverse S-box and InvMixColumns functions.

Parameters:
KEY_BITS, 256, key length; legal values 128/192/256; any other value is an elaboration error.
NK, KEY_BITS/32, key words (4/6/8); derived, not overridable.
NR, NK+6, number of rounds (10/12/14); derived.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
key_valid  input  1  key_in offered
key_ready  output  1  key accepted on key_valid&key_ready edge
key_in  input  KEY_BITS  cipher key, FIPS byte order (MSB = first key byte)
in_valid  input  1  cipher offered
in_ready  output  1  cipher accepted on in_valid&in_ready edge
cipher  input  128  ciphertext block, MSB = byte 0
out_valid  output  1  plain valid
out_ready  input  1  sink accepts plain
plain  output  128  plaintext block
busy  output  1  high in KEYEXP or DECRYPT

Behaviour:
- Reset (async, rst=1): state=IDLE, key store marked invalid; key_ready=1, in_ready=0, out_valid=0, plain=0, busy=0. Round counter=0.
- States: IDLE (no key), KEYEXP, READY, DECRYPT, DONE.
- key_ready=1 only in IDLE and READY.
- in_ready = (state==READY) && !key_valid. A key load has priority over a block, and both are never accepted on the same edge.
- IDLE/READY + key handshake -> KEYEXP. key_in is written to words w[0..NK-1]. Key store is invalid until KEYEXP completes.
- KEYEXP: one 32-bit word w[i] per cycle, i=NK..4*(NR+1)-1.
  - Standard RotWord/SubWord/Rcon when i mod NK==0.
  - SubWord-only when NK==8 and i mod 8==4.
  - Duration 4*(NR+1)-NK cycles: 40 (AES-128), 46 (AES-192), 52 (AES-256).
  - Then -> READY.
- READY + in handshake: state reg <= cipher ^ rk[NR], round=NR-1 -> DECRYPT.
- DECRYPT, each cycle:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[round]) for round>=1.
  - round 0 omits InvMixColumns and loads plain; next state DONE.
  - round decrements by 1 each cycle.
- Latency: handshake edge E; out_valid rises at edge E+NR (10/12/14). Throughput one block per NR+1 cycles plus handshake.
- DONE: out_valid=1, plain held stable until out_valid&out_ready edge. Then out_valid=0 -> READY. Back-to-back: next cipher accepted no earlier than the cycle after output drain.
- Key store and plain are not altered by in_valid/key_valid while busy or in DONE (ready=0, inputs ignored).
- New key after blocks: the previous key is discarded and the next block uses the new key only.
- Reset mid-KEYEXP or mid-DECRYPT: immediate abort to IDLE. A new key must be loaded before any block is accepted.
- rk[r] = w[4r..4r+3], word w[4r] in bits 127:96.

Test Plan:
1. KEY_BITS=256, key 000102…1e1f, cipher 8ea2b7ca516745bfeafc49904b496089 -> plain 00112233445566778899aabbccddeeff. key_ready low exactly 52 cycles; out_valid at accept+14.
2. KEY_BITS=128, key 000102…0e0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a -> plain 00112233…eeff. KEYEXP 40 cycles; latency 10.
3. KEY_BITS=192, key 000102…1617, cipher dda97ca4864cdfe06eaf70a0ec0d7191 -> plain 00112233…eeff. KEYEXP 46 cycles; latency 12.
4. AES-256, two back-to-back blocks, out_ready held low 5 cycles on the first -> plain stable, in_ready=0 while stalled. Second block decrypts correctly after drain.
5. Assert in_valid before any key load -> in_ready stays 0, no output. key_valid and in_valid asserted together in READY -> key taken, block waits until KEYEXP done.
6. Assert rst at DECRYPT round 7 -> out_valid=0, busy=0, key_ready=1 immediately. A subsequent block is refused until a key is reloaded.

Source files
------------

// File: rtl/aes_decrypt_iter_if.sv
// Valid/ready stream bundle between a host (key and ciphertext source, plaintext
// sink) and aes_decrypt_iter. KEY_BITS must match the attached core.
interface aes_decrypt_iter_if #(
  parameter int KEY_BITS = 256
);
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_in;
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        cipher;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        plain;
  logic                busy;

  modport master (
    output key_valid, key_in, in_valid, cipher, out_ready,
    input  key_ready, in_ready, out_valid, plain, busy
  );

  modport slave (
    input  key_valid, key_in, in_valid, cipher, out_ready,
    output key_ready, in_ready, out_valid, plain, busy
  );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (AES-128/192/256): expands a loaded key once into a
// round-key store, then runs one inverse round per clock behind valid/ready streams.
module aes_decrypt_iter #(
  parameter int KEY_BITS = 256
) (
  input logic               clk,
  input logic               rst,
  aes_decrypt_iter_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Byte b sits MSB-first in the flat tables, so its top bit is 2047-8b = {~b,3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  // Byte k of the block is row k%4, column k/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, DECRYPT, DONE} state_t;

  state_t       state;
  logic [3:0]   round;
  logic [5:0]   kidx;
  logic [3:0]   kmod;
  logic [7:0]   rcon;
  logic         key_rdy_q;
  logic         blk_rdy_q;
  logic         vld_p1;
  logic         busy_q;
  logic [127:0] plain_p1;

  logic [31:0]  w [NW];
  logic [127:0] blk_p0;

  logic         key_hs;
  logic         blk_hs;
  logic [31:0]  w_prev;
  logic [31:0]  w_tmp;
  logic [31:0]  w_new;
  logic [127:0] rk_cur;
  logic [127:0] rk_last;
  logic [127:0] rnd;
  logic [127:0] rnd_mix;

  assign bus.key_ready = key_rdy_q;
  assign bus.in_ready  = blk_rdy_q & ~bus.key_valid;
  assign bus.out_valid = vld_p1;
  assign bus.plain     = plain_p1;
  assign bus.busy      = busy_q;

  assign key_hs = bus.key_valid & key_rdy_q;
  assign blk_hs = bus.in_valid & bus.in_ready;

  // Key expansion word w[kidx] from w[kidx-1] and w[kidx-NK]; kmod tracks kidx mod NK.
  always_comb begin
    w_prev = w[kidx - 6'd1];
    w_tmp  = w_prev;
    if (kmod == 4'd0)
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h000000};
    else if (NK == 8 && kmod == 4'd4)
      w_tmp = sub_word(w_prev);
    w_new = w[kidx - 6'(NK)] ^ w_tmp;
  end

  assign rk_cur  = {w[{round, 2'b00}], w[{round, 2'b01}], w[{round, 2'b10}], w[{round, 2'b11}]};
  assign rk_last = {w[4*NR], w[4*NR+1], w[4*NR+2], w[4*NR+3]};
  assign rnd     = inv_sub_bytes(inv_shift_rows(blk_p0)) ^ rk_cur;
  assign rnd_mix = inv_mix_columns(rnd);

  // Stage p0: round-key store and iterated cipher state.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int j = 0; j < NK; j++) w[j] <= bus.key_in[KEY_BITS-1-32*j -: 32];
    end else if (state == KEYEXP) begin
      w[kidx] <= w_new;
    end
    if (blk_hs) blk_p0 <= bus.cipher ^ rk_last;
    else if (state == DECRYPT) blk_p0 <= rnd_mix;
  end

  // Stage p1: control FSM and held plaintext.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round     <= 4'd0;
      kidx      <= 6'd0;
      kmod      <= 4'd0;
      rcon      <= 8'h01;
      key_rdy_q <= 1'b1;
      blk_rdy_q <= 1'b0;
      vld_p1    <= 1'b0;
      busy_q    <= 1'b0;
      plain_p1  <= 128'h0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (key_hs) begin
            state     <= KEYEXP;
            kidx      <= 6'(NK);
            kmod      <= 4'd0;
            rcon      <= 8'h01;
            key_rdy_q <= 1'b0;
            blk_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
          end else if (blk_hs) begin
            state     <= DECRYPT;
            round     <= 4'(NR - 1);
            key_rdy_q <= 1'b0;
            blk_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        KEYEXP: begin
          kidx <= kidx + 6'd1;
          kmod <= (kmod == 4'(NK - 1)) ? 4'd0 : kmod + 4'd1;
          if (kmod == 4'd0) rcon <= xtime(rcon);
          if (kidx == 6'(NW - 1)) begin
            state     <= READY;
            key_rdy_q <= 1'b1;
            blk_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        DECRYPT: begin
          if (round != 4'd0) begin
            round <= round - 4'd1;
          end else begin
            state    <= DONE;
            plain_p1 <= rnd;
            vld_p1   <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= READY;
            vld_p1    <= 1'b0;
            key_rdy_q <= 1'b1;
            blk_rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: FIPS-197 vectors for all three key sizes,
// output stall, handshake priority and reset abort.
module tb_aes_decrypt_iter;
  localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] sel = 2'd0;

  logic         key_valid = 1'b0;
  logic [255:0] key_in    = '0;
  logic         in_valid  = 1'b0;
  logic [127:0] cipher    = '0;
  logic         out_ready = 1'b1;

  logic         key_ready;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] plain;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  aes_decrypt_iter_if #(.KEY_BITS(256)) ifa ();
  aes_decrypt_iter_if #(.KEY_BITS(128)) ifb ();
  aes_decrypt_iter_if #(.KEY_BITS(192)) ifc ();

  aes_decrypt_iter #(.KEY_BITS(256)) dut256 (.clk(clk), .rst(rst), .bus(ifa));
  aes_decrypt_iter #(.KEY_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(ifb));
  aes_decrypt_iter #(.KEY_BITS(192)) dut192 (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  assign ifa.key_valid = key_valid && sel == 2'd0;
  assign ifb.key_valid = key_valid && sel == 2'd1;
  assign ifc.key_valid = key_valid && sel == 2'd2;
  assign ifa.in_valid  = in_valid && sel == 2'd0;
  assign ifb.in_valid  = in_valid && sel == 2'd1;
  assign ifc.in_valid  = in_valid && sel == 2'd2;
  assign ifa.key_in    = key_in;
  assign ifb.key_in    = key_in[255:128];
  assign ifc.key_in    = key_in[255:64];
  assign ifa.cipher    = cipher;
  assign ifb.cipher    = cipher;
  assign ifc.cipher    = cipher;
  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;
  assign ifc.out_ready = out_ready;

  always_comb begin
    case (sel)
      2'd1: begin
        key_ready = ifb.key_ready; in_ready = ifb.in_ready; out_valid = ifb.out_valid;
        plain = ifb.plain; busy = ifb.busy;
      end
      2'd2: begin
        key_ready = ifc.key_ready; in_ready = ifc.in_ready; out_valid = ifc.out_valid;
        plain = ifc.plain; busy = ifc.busy;
      end
      default: begin
        key_ready = ifa.key_ready; in_ready = ifa.in_ready; out_valid = ifa.out_valid;
        plain = ifa.plain; busy = ifa.busy;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the key handshake edge
  // once key_ready has come back.
  task automatic load_key(input logic [255:0] k, input int kexp, input string tag);
    bit ok;
    int n;
    key_in    = k;
    key_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (key_ready) ok = 1'b1;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk({tag, " key handshake"}, 128'(ok), 128'd1);
    chk({tag, " busy in keyexp"}, 128'(busy), 128'd1);
    n = 0;
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " keyexp cycles"}, 128'(n), 128'(kexp));
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic send(input logic [127:0] c, output bit ok);
    cipher   = c;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat, input logic [127:0] exp, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'(lat));
    chk({tag, " plain"}, plain, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int bad;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset key_ready", 128'(key_ready), 128'd1);
    chk("reset in_ready", 128'(in_ready), 128'd0);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset plain", plain, 128'h0);
    chk("reset busy", 128'(busy), 128'd0);

    // Block offered before any key: never taken.
    cipher = C256;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) bad++;
    end
    in_valid = 1'b0;
    chk("no key block refused", 128'(bad), 128'd0);

    // AES-256
    load_key(KEY, 52, "aes256");
    send(C256, ok);
    chk("aes256 accept", 128'(ok), 128'd1);
    chk("aes256 busy", 128'(busy), 128'd1);
    wait_out(14, PT, "aes256");
    @(negedge clk);

    // AES-128
    sel = 2'd1;
    load_key(KEY, 40, "aes128");
    send(C128, ok);
    chk("aes128 accept", 128'(ok), 128'd1);
    wait_out(10, PT, "aes128");
    @(negedge clk);

    // AES-192
    sel = 2'd2;
    load_key(KEY, 46, "aes192");
    send(C192, ok);
    chk("aes192 accept", 128'(ok), 128'd1);
    wait_out(12, PT, "aes192");
    @(negedge clk);

    // Output stall with a second block waiting.
    sel = 2'd0;
    @(negedge clk);
    out_ready = 1'b0;
    send(C256, ok);
    chk("stall accept1", 128'(ok), 128'd1);
    wait_out(14, PT, "stall blk1");
    cipher   = C256;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (plain !== PT || !out_valid || in_ready) bad++;
    end
    chk("stall hold", 128'(bad), 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall drained", 128'(out_valid), 128'd0);
    send(C256, ok);
    chk("stall accept2", 128'(ok), 128'd1);
    wait_out(14, PT, "stall blk2");
    @(negedge clk);

    // Key and block offered together: key wins, block waits for KEYEXP.
    cipher    = C256;
    in_valid  = 1'b1;
    key_in    = KEY;
    key_valid = 1'b1;
    #1;
    chk("key priority in_ready", 128'(in_ready), 128'd0);
    load_key(KEY, 52, "rekey");
    send(C256, ok);
    chk("rekey accept", 128'(ok), 128'd1);
    wait_out(14, PT, "rekey");
    @(negedge clk);

    // Reset while round 7 is pending.
    send(C256, ok);
    chk("abort accept", 128'(ok), 128'd1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 128'(out_valid), 128'd0);
    chk("abort busy", 128'(busy), 128'd0);
    chk("abort key_ready", 128'(key_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    cipher   = C256;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) bad++;
    end
    in_valid = 1'b0;
    chk("abort block refused", 128'(bad), 128'd0);
    load_key(KEY, 52, "reload");
    send(C256, ok);
    chk("reload accept", 128'(ok), 128'd1);
    wait_out(14, PT, "reload");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
